cell_mem_ctrl: RTL and testbench

Sequencing and arbitration controller for one single-port cell position RAM. It shares that RAM between two requesters. The force-evaluation side issues a stream-read request: the controller fetches the particle count, then every particle position in the cell. The motion-update side issues single-word write requests. The block sits between the position cache logic and the cell memory, and it guarantees that at most one RAM operation is issued per cycle.

---
 rtl/cell_mem_pkg.sv | 25 ++
 rtl/cell_mem_arb.sv | 36 +++
 rtl/cell_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cell_mem_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_mem_pkg.sv
// Shared types for the cell position RAM controller: FSM states and read tags.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package cell_mem_pkg;

  // Width of the particle id carried in a read tag; matches the RAM address width.
  localparam int PID_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CNT_ISS,
    CNT_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // One in-flight RAM read: which particle it belongs to, or whether it is the count word.
  typedef struct packed {
    logic             valid;
    logic             is_count;
    logic [PID_W-1:0] pid;
  } tag_t;

endpackage

// File: rtl/cell_mem_arb.sv
// Single-port grant logic between the stream reader and the write requester.
// Latency: combinational grants; the burst counter updates on the next edge.
// Backpressure: writes win, except that after WR_BURST_MAX writes in a row one read is forced.
module cell_mem_arb #(
  parameter int WR_BURST_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic rd_want,
  input  logic wr_req,
  output logic rd_grant,
  output logic wr_grant
);

  localparam int CW = $clog2(WR_BURST_MAX + 1);

  logic [CW-1:0] burst_cnt;
  logic          force_rd;

  // A saturated counter hands the next slot to a waiting reader.
  assign force_rd = rd_want && (burst_cnt == CW'(WR_BURST_MAX));
  assign wr_grant = wr_req && !force_rd;
  assign rd_grant = rd_want && !wr_grant;

  // Count writes that starve a pending read; clear once the read gets through.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (rd_grant) begin
      burst_cnt <= '0;
    end else if (wr_grant && rd_want && (burst_cnt != CW'(WR_BURST_MAX))) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cell_mem_ctrl.sv
// Streams a whole cell (count word, then every particle) out of a single-port RAM while sharing it with writes.
// Latency: rd_data arrives 2 cycles after its read is issued; a write commits in the cycle wr_ack is high.
// Backpressure: wr_req holds until wr_ack; each granted write delays the remaining stream reads by one cycle.
module cell_mem_ctrl
  import cell_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] rd_count,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  cnt_err
);

  localparam logic [ADDR_WIDTH-1:0] MAX_PID = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic                  rd_want;
  logic                  rd_grant;
  logic                  wr_grant;
  logic                  count_arrived;
  tag_t                  issue_tag;
  tag_t                  tag1;
  tag_t                  tag2;

  assign rd_want = (state == CNT_ISS) || (state == STREAM);
  assign rd_addr = (state == CNT_ISS) ? '0 : next_addr;

  cell_mem_arb #(
    .WR_BURST_MAX(WR_BURST_MAX)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .rd_want (rd_want),
    .wr_req  (wr_req),
    .rd_grant(rd_grant),
    .wr_grant(wr_grant)
  );

  assign wr_ack = wr_grant;

  // Drive the RAM port from whichever side was granted; an idle port is all zeros.
  always_comb begin
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    if (wr_grant) begin
      mem_wren    = 1'b1;
      mem_address = wr_addr;
      mem_data    = wr_data;
    end else if (rd_grant) begin
      mem_rden    = 1'b1;
      mem_address = rd_addr;
    end
  end

  // Tag describing the read issued this cycle, or an empty tag when no read goes out.
  always_comb begin
    issue_tag = '0;
    if (rd_grant) begin
      issue_tag.valid    = 1'b1;
      issue_tag.is_count = (state == CNT_ISS);
      issue_tag.pid      = PID_W'(rd_addr);
    end
  end

  // Two-stage tag pipe mirroring the RAM read latency so stage 2 lines up with mem_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1 <= issue_tag;
      tag2 <= tag1;
    end
  end

  assign count_arrived = tag2.valid && tag2.is_count;
  assign cnt_raw       = mem_q[ADDR_WIDTH-1:0];
  assign rd_valid      = tag2.valid && !tag2.is_count;
  assign rd_pid        = ADDR_WIDTH'(tag2.pid);
  assign rd_data       = mem_q;

  // Stream sequencer: fetch and clamp the count, walk addresses 1..count, drain, then pulse done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rd_busy   <= 1'b0;
      rd_done   <= 1'b0;
      next_addr <= '0;
      rd_count  <= '0;
      cnt_err   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            state   <= CNT_ISS;
            rd_busy <= 1'b1;
          end
        end
        CNT_ISS: begin
          if (rd_grant) begin
            state <= CNT_WAIT;
          end
        end
        CNT_WAIT: begin
          if (count_arrived) begin
            // The latched copy is what the stream walks; later writes to word 0 do not disturb it.
            if (cnt_raw > MAX_PID) begin
              rd_count <= MAX_PID;
              cnt_err  <= 1'b1;
            end else begin
              rd_count <= cnt_raw;
            end
            next_addr <= ADDR_WIDTH'(1);
            if (cnt_raw == '0) begin
              state   <= DONE;
              rd_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_grant) begin
            next_addr <= next_addr + 1'b1;
            if (next_addr == rd_count) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Once stage 1 is empty the last entry leaves stage 2 on this edge.
          if (!tag1.valid) begin
            state   <= DONE;
            rd_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_mem_ctrl.sv
// Directed bench for cell_mem_ctrl with a 2-cycle RAM model and a read-data scoreboard.
// Latency: expectations are hand-computed cycle numbers relative to the rd_start edge.
// Backpressure: a background writer holds wr_req and advances only on wr_ack.
module tb_cell_mem_ctrl;

  logic        clock;
  logic        reset;
  logic        rd_start;
  logic        rd_busy;
  logic        rd_valid;
  logic [7:0]  rd_pid;
  logic [95:0] rd_data;
  logic        rd_done;
  logic [7:0]  rd_count;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [95:0] wr_data;
  logic        wr_ack;
  logic [7:0]  mem_address;
  logic [95:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic [95:0] mem_q;
  logic        cnt_err;

  cell_mem_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .rd_start   (rd_start),
    .rd_busy    (rd_busy),
    .rd_valid   (rd_valid),
    .rd_pid     (rd_pid),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .rd_count   (rd_count),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .cnt_err    (cnt_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  int base = 0;
  int vectors = 0;
  int miscompares = 0;
  int overlap = 0;
  int ack_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [95:0] pos_word(input int k);
    return {32'(k * 7 + 256), 32'hA000_0000 | 32'(k), 32'(k) ^ 32'h0000_0F0F};
  endfunction

  // RAM model: 2-cycle read latency, writes land at the edge; bench-side loads share the same process.
  logic [95:0] ram [0:255];
  logic [95:0] q1, q2;
  logic        load_all;
  logic        bd_we;
  logic [95:0] bd_dat;

  always @(posedge clock) begin
    if (load_all) begin
      for (int k = 1; k < 256; k++) ram[k] <= pos_word(k);
    end
    if (bd_we) ram[0] <= bd_dat;
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) q1 <= ram[mem_address];
    else q1 <= '0;
    q2 <= q1;
  end
  assign mem_q = q2;

  typedef struct {
    int          pid;
    logic [95:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every rd_valid pops the next expected particle and checks pid, data and cycle.
  always @(negedge clock) begin
    if (mem_rden && mem_wren) overlap++;
    if (wr_ack) ack_cnt++;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_valid_unexpected: got pid %0d expected no output", rd_pid);
      end else begin
        mon_e = sb.pop_front();
        check("rd_pid", 96'(rd_pid), 96'(mon_e.pid));
        check("rd_data", rd_data, mon_e.data);
        check("rd_valid_cycle", 96'(cyc - base), 96'(mon_e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word0(input logic [95:0] v);
    bd_we  = 1'b1;
    bd_dat = v;
    tick();
    bd_we  = 1'b0;
  endtask

  task automatic push_stream(input int n, input int first, input int stride);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.pid  = k;
      e.data = pos_word(k);
      e.cyc  = first + stride * (k - 1);
      sb.push_back(e);
    end
  endtask

  // Called in cycle 0; returns in cycle 1 with base set so that cyc - base is the cycle number.
  task automatic start_stream();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    base = cyc - 1;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input int exp_count, input logic exp_err);
    int got;
    got = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (rd_done) begin
        got = cyc - base;
        break;
      end
    end
    check({name, "_done_cycle"}, 96'(got), 96'(exp_cyc));
    check({name, "_rd_count"}, 96'(rd_count), 96'(exp_count));
    check({name, "_cnt_err"}, 96'(cnt_err), 96'(exp_err));
    check({name, "_busy_at_done"}, 96'(rd_busy), 96'(1));
    check({name, "_sb_empty"}, 96'(sb.size()), 96'(0));
    tick();
  endtask

  task automatic bg_writer(input int n);
    logic       a;
    logic [7:0] addr;
    addr    = 8'd100;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = ~pos_word(int'(addr));
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      a = wr_ack;
      tick();
      if (a) begin
        addr    = addr + 8'd1;
        wr_addr = addr;
        wr_data = ~pos_word(int'(addr));
      end
    end
    wr_req = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rd_start = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    bd_we    = 1'b0;
    bd_dat   = '0;
    load_all = 1'b0;
    tick();
    load_all = 1'b1;
    tick();
    load_all = 1'b0;
    repeat (2) tick();

    // Reset state.
    @(negedge clock);
    check("rst_rd_busy", 96'(rd_busy), 96'(0));
    check("rst_rd_valid", 96'(rd_valid), 96'(0));
    check("rst_rd_done", 96'(rd_done), 96'(0));
    check("rst_rd_count", 96'(rd_count), 96'(0));
    check("rst_cnt_err", 96'(cnt_err), 96'(0));
    check("rst_mem_rden", 96'(mem_rden), 96'(0));
    check("rst_mem_address", 96'(mem_address), 96'(0));
    tick();
    reset = 1'b0;
    tick();

    // Count 3, uncontended; upper bits of word 0 must be ignored.
    set_word0(96'h0000_ABCD_0000_0000_1234_0003);
    push_stream(3, 6, 1);
    start_stream();
    wait_done("s1", 9, 3, 1'b0);

    // Count 0: no particles, done in cycle 4, busy for cycles 1-4.
    set_word0(96'd0);
    start_stream();
    @(negedge clock);
    check("s2_busy_cycle1", 96'(rd_busy), 96'(1));
    wait_done("s2", 4, 0, 1'b0);
    @(negedge clock);
    check("s2_busy_after", 96'(rd_busy), 96'(0));
    tick();

    // Count 250 clamps to 219 and sets the sticky error.
    set_word0({88'h0, 8'd250});
    push_stream(219, 6, 1);
    start_stream();
    wait_done("s4", 225, 219, 1'b1);
    @(negedge clock);
    check("s4_cnt_err_sticky", 96'(cnt_err), 96'(1));
    tick();

    // Count 10 with writes held the whole time: 4 write acks, then 1 read.
    set_word0(96'd10);
    push_stream(10, 14, 5);
    ack_cnt = 0;
    fork
      begin
        start_stream();
        wait_done("s3", 60, 10, 1'b1);
      end
      bg_writer(62);
    join
    check("s3_wr_ack_count", 96'(ack_cnt), 96'(51));
    check("s3_last_write", ram[150], ~pos_word(150));

    // Write of 5 to word 0 mid-stream: this stream still ends at 3, the next streams 5.
    set_word0(96'd3);
    push_stream(3, 7, 1);
    fork
      begin
        start_stream();
        wait_done("s5a", 10, 3, 1'b1);
      end
      begin
        repeat (4) tick();
        wr_req  = 1'b1;
        wr_addr = 8'd0;
        wr_data = 96'd5;
        @(negedge clock);
        check("s5_wr0_ack", 96'(wr_ack), 96'(1));
        tick();
        wr_req = 1'b0;
      end
    join
    check("s5_word0", ram[0], 96'd5);
    push_stream(5, 6, 1);
    start_stream();
    wait_done("s5b", 11, 5, 1'b1);

    // Reset during STREAM; rd_start while reset is high is ignored; in-flight reads are dropped.
    set_word0(96'd3);
    start_stream();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    rd_start = 1'b1;
    @(negedge clock);
    check("s6_rd_valid", 96'(rd_valid), 96'(0));
    check("s6_rd_busy", 96'(rd_busy), 96'(0));
    check("s6_cnt_err", 96'(cnt_err), 96'(0));
    check("s6_rd_count", 96'(rd_count), 96'(0));
    tick();
    reset    = 1'b0;
    rd_start = 1'b0;
    @(negedge clock);
    check("s6_busy_ignored_start", 96'(rd_busy), 96'(0));
    tick();
    @(negedge clock);
    check("s6_busy_later", 96'(rd_busy), 96'(0));
    check("s6_rd_valid_later", 96'(rd_valid), 96'(0));
    tick();
    push_stream(3, 6, 1);
    start_stream();
    wait_done("s6", 9, 3, 1'b0);

    check("rden_wren_overlap", 96'(overlap), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
